// File: rtl/ps_guard_pkg.sv
// ps_guard_pkg: shared types for the PacketStream packet guard.
//   ps_guard_state_t : guard FSM state encoding (IDLE, BUSY, DROP)
package ps_guard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } ps_guard_state_t;

endpackage

// File: rtl/ps_guard_if.sv
// ps_guard_if: PacketStream word handshake (data, valid, end-of-packet, ready).
//   master : drives dat/val/eop, receives rdy
//   slave  : receives dat/val/eop, drives rdy
interface ps_guard_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dat;
  logic             val;
  logic             eop;
  logic             rdy;

  modport master (output dat, output val, output eop, input rdy);
  modport slave  (input dat, input val, input eop, output rdy);
endinterface

// File: rtl/ps_sat_counter.sv
// ps_sat_counter: up-counter that holds at all-ones.
//   reset in  async active-high reset (count -> 0)
//   clk   in  clock
//   clr   in  restart count; with inc the count restarts at 1, otherwise at 0
//   inc   in  count one event
//   cnt   out current count
module ps_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             reset,
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = &r_cnt;
  assign cnt   = r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= inc ? WIDTH'(1) : '0;
    end else if (inc && !w_sat) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ps_guard.sv
// ps_guard: PacketStream packet guard. Closes the outbound packet early on an
// abort or when the runtime maximum length is reached, then discards the rest
// of the inbound packet up to its EOP. A one-word holding buffer lets the last
// forwarded word carry a forced EOP.
//   reset     in   async active-high reset
//   clk       in   clock
//   abort     in   abort request for the packet currently in the buffer
//   max_len   in   max words per packet, 0 = unlimited
//   i_ps      slave   inbound stream (dat/val/eop in, rdy out)
//   o_ps      master  outbound stream (dat/val/eop out, rdy in)
//   o_err     out  truncated-packet flag, qualifies o_ps.eop (only with PS_GUARD_ERR_EN)
//   dropping  out  high while discarding the remainder of a truncated packet
//   trunc_cnt out  saturating count of truncated packets
// Build option: define PS_GUARD_ERR_EN to add the o_err port.
//
// state | meaning
// IDLE  | no word buffered, waiting for the first word of a packet
// BUSY  | one word buffered, forwarding the packet
// DROP  | packet truncated, discarding inbound words up to the EOP
module ps_guard
  import ps_guard_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 abort,
  input  logic [LEN_WIDTH-1:0] max_len,
  ps_guard_if.slave            i_ps,
  ps_guard_if.master           o_ps,
`ifdef PS_GUARD_ERR_EN
  output logic                 o_err,
`endif
  output logic                 dropping,
  output logic [CNT_WIDTH-1:0] trunc_cnt
);

  ps_guard_state_t      r_state;
  logic [WIDTH-1:0]     r_buf_dat;
  logic                 r_buf_eop;
  logic                 r_abort_hold;
  logic [LEN_WIDTH-1:0] w_len_cnt;

  logic w_busy, w_lim_hit, w_close;
  logic w_o_val, w_o_eop, w_xfer;
  logic w_start, w_cont, w_load, w_trunc;

  assign w_busy    = (r_state == BUSY);
  // A buffered EOP is a natural end, never a limit hit.
  assign w_lim_hit = (max_len != '0) && (w_len_cnt >= max_len) && !r_buf_eop;
  assign w_close   = abort | r_abort_hold | w_lim_hit;

  // A non-EOP word only leaves when its successor is presented, so the
  // buffer always knows whether it holds the last word of the packet.
  assign w_o_val = w_busy & (i_ps.val | r_buf_eop | w_close);
  assign w_o_eop = w_busy & (r_buf_eop | w_close);
  assign w_xfer  = w_o_val & o_ps.rdy;

  assign w_start = ((r_state == IDLE) & i_ps.val) | (w_xfer & r_buf_eop & i_ps.val);
  assign w_cont  = w_xfer & ~w_o_eop;
  assign w_load  = w_start | w_cont;
  assign w_trunc = w_xfer & w_close & ~r_buf_eop;

  assign o_ps.dat  = r_buf_dat;
  assign o_ps.val  = w_o_val;
  assign o_ps.eop  = w_o_eop;
  assign i_ps.rdy  = w_busy ? o_ps.rdy : 1'b1;
  assign dropping  = (r_state == DROP);
`ifdef PS_GUARD_ERR_EN
  assign o_err     = w_busy & w_close & ~r_buf_eop;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_buf_dat    <= '0;
      r_buf_eop    <= 1'b0;
      r_abort_hold <= 1'b0;
    end else begin
      if (w_load) begin
        r_buf_dat <= i_ps.dat;
        r_buf_eop <= i_ps.eop;
      end
      case (r_state)
        IDLE: begin
          r_abort_hold <= 1'b0;
          if (i_ps.val) r_state <= BUSY;
        end
        BUSY: begin
          if (w_xfer) begin
            r_abort_hold <= 1'b0;
            if (w_trunc) begin
              // The word accepted alongside the truncating transfer is discarded.
              r_state <= (i_ps.val && i_ps.eop) ? IDLE : DROP;
            end else if (r_buf_eop && !i_ps.val) begin
              r_state <= IDLE;
            end
          end else if (abort) begin
            r_abort_hold <= 1'b1;
          end
        end
        DROP: begin
          r_abort_hold <= 1'b0;
          if (i_ps.val && i_ps.eop) r_state <= IDLE;
        end
        default: begin
          r_state      <= IDLE;
          r_abort_hold <= 1'b0;
        end
      endcase
    end
  end

  ps_sat_counter #(.WIDTH(LEN_WIDTH)) u_len_cnt (
    .reset (reset),
    .clk   (clk),
    .clr   (w_start),
    .inc   (w_load),
    .cnt   (w_len_cnt)
  );

  ps_sat_counter #(.WIDTH(CNT_WIDTH)) u_trunc_cnt (
    .reset (reset),
    .clk   (clk),
    .clr   (1'b0),
    .inc   (w_trunc),
    .cnt   (trunc_cnt)
  );

endmodule
